alu_issue_ctrl: RTL and testbench

Issue stage that sits in front of the 32-bit ALU as its initiator: accepts decoded instruction fields over a valid/ready handshake, translates ALUOp/funct into the ALU's 4-bit control code, selects and conditions operands, drives the ALU, and captures result/zero into an output register. Two-stage pipeline with full backpressure, plus completion and illegal-op counters for the CPU's debug path.

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode and operand select in front of a 32-bit ALU,
// two-stage valid/ready pipeline with saturating debug counters.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        alu_op_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              use_imm_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_result_o,
  output logic              out_zero_o,
  output logic              out_illegal_o,
  output logic [CNT_W-1:0]  done_cnt_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0100;
  localparam logic [3:0] C_SRA = 4'b0101;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_ILL = 4'b1000;
  localparam logic [3:0] C_BNE = 4'b1110;
  localparam logic [3:0] C_SRL = 4'b1111;

  logic [3:0]        w_ctrl;
  logic              w_illegal;
  logic              w_shift;
  logic [DATA_W-1:0] w_src2_raw;
  logic [DATA_W-1:0] w_src2;
  logic              w_s2_adv;
  logic              w_accept;
  logic              w_out_hs;

  logic              r_s1_valid;
  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_s1_ill;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_s2_ill;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [CNT_W-1:0]  r_ill_cnt;

  always_comb begin
    w_ctrl    = C_ADD;
    w_illegal = 1'b0;
    unique case (alu_op_i)
      2'b00: w_ctrl = C_ADD;
      2'b01: begin
        unique case (funct3_i)
          3'b000:  w_ctrl = C_SUB;
          3'b001:  w_ctrl = C_BNE;
          default: begin
            w_ctrl    = C_ILL;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        unique case (funct3_i)
          3'b000: w_ctrl = (!alu_op_i[0] && funct7b5_i) ? C_SUB : C_ADD;
          3'b001: w_ctrl = C_SLL;
          3'b010: w_ctrl = C_SLT;
          3'b100: w_ctrl = C_XOR;
          3'b101: w_ctrl = funct7b5_i ? C_SRA : C_SRL;
          3'b110: w_ctrl = C_OR;
          3'b111: w_ctrl = C_AND;
          default: begin
            w_ctrl    = C_ILL;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // shift amounts are trimmed to 5 bits so the ALU never sees a wide shift
  assign w_shift    = (w_ctrl == C_SLL) || (w_ctrl == C_SRA) ||
                      (w_ctrl == C_SRL);
  assign w_src2_raw = use_imm_i ? imm_i : rs2_data_i;
  assign w_src2     = w_shift ? {{(DATA_W-5){1'b0}}, w_src2_raw[4:0]}
                              : w_src2_raw;

  assign w_s2_adv   = !r_s2_valid || out_ready_i;
  assign in_ready_o = !r_s1_valid || w_s2_adv;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_out_hs   = r_s2_valid && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_ctrl     <= 4'b0000;
      r_src1     <= '0;
      r_src2     <= '0;
      r_s1_ill   <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready_o) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_ctrl   <= w_ctrl;
        r_src1   <= rs1_data_i;
        r_src2   <= w_src2;
        r_s1_ill <= w_illegal;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_s2_ill   <= 1'b0;
    end else if (flush_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= alu_result_i;
        r_zero   <= alu_zero_i;
        r_s2_ill <= r_s1_ill;
      end
    end
  end

  // a handshake in a flush cycle still completes and is counted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done_cnt <= '0;
      r_ill_cnt  <= '0;
    end else begin
      if (w_out_hs && !(&r_done_cnt))
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      if (w_out_hs && r_s2_ill && !(&r_ill_cnt))
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign alu_src1_o    = r_src1;
  assign alu_src2_o    = r_src2;
  assign alu_ctrl_o    = r_ctrl;
  assign out_valid_o   = r_s2_valid;
  assign out_result_o  = r_result;
  assign out_zero_o    = r_zero;
  assign out_illegal_o = r_s2_ill;
  assign done_cnt_o    = r_done_cnt;
  assign illegal_cnt_o = r_ill_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl
// against an instruction-level reference model and an ALU model.
module tb_alu_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  alu_op_i;
  logic [2:0]  funct3_i;
  logic        funct7b5_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic        use_imm_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic        out_zero_o;
  logic        out_illegal_o;
  logic [15:0] done_cnt_o;
  logic [15:0] illegal_cnt_o;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int exp_ill = 0;
  logic [33:0] q[$];

  alu_issue_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_i(alu_op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .use_imm_i(use_imm_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_zero_o(out_zero_o),
    .out_illegal_o(out_illegal_o),
    .done_cnt_o(done_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ALU model: BNE yields 1 on equal operands so zero means "not equal"
  always_comb begin
    alu_result_i = 32'd0;
    case (alu_ctrl_o)
      4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
      4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
      4'b0011: alu_result_i = alu_src1_o ^ alu_src2_o;
      4'b0100: alu_result_i = alu_src1_o << alu_src2_o;
      4'b0101: alu_result_i = 32'($signed(alu_src1_o) >>> alu_src2_o);
      4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
      4'b0111: alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      4'b1100: alu_result_i = ~(alu_src1_o | alu_src2_o);
      4'b1101: alu_result_i = ~(alu_src1_o & alu_src2_o);
      4'b1110: alu_result_i = (alu_src1_o == alu_src2_o) ? 32'd1 : 32'd0;
      4'b1111: alu_result_i = alu_src1_o >> alu_src2_o;
      default: alu_result_i = 32'd0;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
  end

  // instruction-level expectation: {illegal, zero, result}
  function automatic logic [33:0] ref_op(input logic [1:0] op,
      input logic [2:0] f3, input logic b5, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] imm, input logic ui);
    logic [31:0] y;
    logic [31:0] r;
    logic        ill;
    y = ui ? imm : b;
    r = 32'd0;
    ill = 1'b0;
    if (op == 2'd0) r = a + y;
    else if (op == 2'd1) begin
      if (f3 == 3'd0) r = a - y;
      else if (f3 == 3'd1) r = (a == y) ? 32'd1 : 32'd0;
      else ill = 1'b1;
    end else begin
      case (f3)
        3'd0: r = (op == 2'd2 && b5) ? a - y : a + y;
        3'd1: r = a << y[4:0];
        3'd2: r = {31'd0, $signed(a) < $signed(y)};
        3'd3: ill = 1'b1;
        3'd4: r = a ^ y;
        3'd5: r = b5 ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
        3'd6: r = a | y;
        default: r = a & y;
      endcase
    end
    return {ill, r == 32'd0, r};
  endfunction

  task automatic put(input logic [1:0] op, input logic [2:0] f3,
      input logic b5, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic ui);
    alu_op_i = op; funct3_i = f3; funct7b5_i = b5;
    rs1_data_i = a; rs2_data_i = b; imm_i = imm; use_imm_i = ui;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    put(2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk_i);
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    checks++; if ({out_result_o, out_zero_o, out_illegal_o} !== 34'd0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_result_o); end
    checks++; if ({alu_src1_o, alu_src2_o, alu_ctrl_o} !== 68'd0) begin failures++; $display("FAIL rst_alu_drive got=%h/%h/%h exp=0", alu_src1_o, alu_src2_o, alu_ctrl_o); end
    checks++; if ({done_cnt_o, illegal_cnt_o} !== 32'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", done_cnt_o, illegal_cnt_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_add;
    put(2'd2, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0);
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (alu_ctrl_o !== 4'b0010) begin failures++; $display("FAIL add_ctrl got=%b exp=0010", alu_ctrl_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL add_latency got=%b exp=0", out_valid_o); end
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid_o); end
    checks++; if ({out_result_o, out_zero_o} !== {32'd12, 1'b0}) begin failures++; $display("FAIL add_result got=%0d z=%b exp=12 z=0", out_result_o, out_zero_o); end
    @(negedge clk_i);
    exp_done++;
    checks++; if (done_cnt_o !== 16'(exp_done)) begin failures++; $display("FAIL add_done_cnt got=%0d exp=%0d", done_cnt_o, exp_done); end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 2; k++) begin
      put(2'd1, (k == 0) ? 3'd1 : 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0);
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      @(posedge clk_i); #1 in_valid_i = 1'b0;
      @(negedge clk_i);
      checks++; if (alu_ctrl_o !== ((k == 0) ? 4'b1110 : 4'b0110)) begin failures++; $display("FAIL branch_ctrl k=%0d got=%b", k, alu_ctrl_o); end
      @(negedge clk_i);
      checks++; if ({out_valid_o, out_zero_o} !== {1'b1, k == 1}) begin failures++; $display("FAIL branch_zero k=%0d got v=%b z=%b exp z=%0d", k, out_valid_o, out_zero_o, k); end
      @(negedge clk_i);
      exp_done++;
    end
  endtask

  task automatic test_srai;
    put(2'd3, 3'd5, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h21, 1'b1);
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (alu_src2_o !== 32'd1) begin failures++; $display("FAIL srai_src2 got=%h exp=1", alu_src2_o); end
    checks++; if (alu_ctrl_o !== 4'b0101) begin failures++; $display("FAIL srai_ctrl got=%b exp=0101", alu_ctrl_o); end
    @(negedge clk_i);
    checks++; if (out_result_o !== 32'hC000_0000) begin failures++; $display("FAIL srai_result got=%h exp=c0000000", out_result_o); end
    @(negedge clk_i);
    exp_done++;
  endtask

  task automatic test_illegal;
    put(2'd2, 3'd3, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0);
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (alu_ctrl_o !== 4'b1000) begin failures++; $display("FAIL ill_ctrl got=%b exp=1000", alu_ctrl_o); end
    @(negedge clk_i);
    checks++; if ({out_result_o, out_illegal_o} !== {32'd0, 1'b1}) begin failures++; $display("FAIL ill_out got=%h ill=%b exp=0 ill=1", out_result_o, out_illegal_o); end
    @(negedge clk_i);
    exp_done++; exp_ill++;
    checks++; if (illegal_cnt_o !== 16'(exp_ill)) begin failures++; $display("FAIL ill_cnt got=%0d exp=%0d", illegal_cnt_o, exp_ill); end
    checks++; if (done_cnt_o !== 16'(exp_done)) begin failures++; $display("FAIL ill_done_cnt got=%0d exp=%0d", done_cnt_o, exp_done); end
  endtask

  task automatic test_stream(input int nops, input bit rnd, output bit saw_full);
    int sent;
    int cyc;
    bit have;
    logic [33:0] e;
    sent = 0; cyc = 0; have = 1'b0; saw_full = 1'b0;
    while ((sent < nops || q.size() != 0) && cyc < 4000) begin
      if (!have && sent < nops) begin
        put(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) rs2_data_i = rs1_data_i;
        if ($urandom_range(0, 3) == 0) imm_i = 32'($urandom_range(0, 63));
        have = 1'b1;
      end
      in_valid_i = have && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready_i = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 2 && cyc < 5);
      #1;
      checks++; if (in_ready_o !== (q.size() < 2 || out_ready_i)) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready_o, q.size()); end
      if (q.size() == 2 && !out_ready_i) saw_full = 1'b1;
      if (q.size() == 2) begin
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL stream_full_valid cyc=%0d got=%b exp=1", cyc, out_valid_o); end
      end else if (q.size() == 0) begin
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL stream_empty_valid cyc=%0d got=%b exp=0", cyc, out_valid_o); end
      end
      if (out_valid_o && out_ready_i && q.size() != 0) begin
        e = q.pop_front();
        checks++; if ({out_illegal_o, out_zero_o, out_result_o} !== e) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, {out_illegal_o, out_zero_o, out_result_o}, e); end
        exp_done++; exp_ill += int'(e[33]);
      end
      if (in_valid_i && in_ready_o)
        begin
          q.push_back(ref_op(alu_op_i, funct3_i, funct7b5_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i));
          sent++; have = 1'b0;
        end
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    checks++; if (cyc >= 4000) begin failures++; $display("FAIL stream_timeout sent=%0d pending=%0d", sent, q.size()); end
    checks++; if (done_cnt_o !== 16'(exp_done)) begin failures++; $display("FAIL stream_done_cnt got=%0d exp=%0d", done_cnt_o, exp_done); end
    checks++; if (illegal_cnt_o !== 16'(exp_ill)) begin failures++; $display("FAIL stream_ill_cnt got=%0d exp=%0d", illegal_cnt_o, exp_ill); end
  endtask

  task automatic test_back_to_back;
    bit sf;
    test_stream(4, 1'b0, sf);
    checks++; if (sf !== 1'b1) begin failures++; $display("FAIL b2b_backpressure got=%b exp=1", sf); end
  endtask

  task automatic fill_two;
    out_ready_i = 1'b0;
    put(2'd2, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0);
    in_valid_i = 1'b1;
    @(posedge clk_i); #1 put(2'd2, 3'd4, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0);
    @(posedge clk_i); #1 in_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_async_reset;
    fill_two();
    checks++; if ({out_valid_o, in_ready_o} !== 2'b10) begin failures++; $display("FAIL arst_full got v=%b r=%b exp v=1 r=0", out_valid_o, in_ready_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid_o); end
    checks++; if ({done_cnt_o, illegal_cnt_o} !== 32'd0) begin failures++; $display("FAIL arst_counters got=%0d/%0d exp=0/0", done_cnt_o, illegal_cnt_o); end
    checks++; if ({out_result_o, alu_ctrl_o} !== 36'd0) begin failures++; $display("FAIL arst_regs got=%h/%b exp=0", out_result_o, alu_ctrl_o); end
    @(negedge clk_i);
    rst_i = 1'b0; out_ready_i = 1'b1;
    q.delete(); exp_done = 0; exp_ill = 0;
    repeat (2) begin
      @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL arst_drained got=%b exp=0", out_valid_o); end
    end
  endtask

  task automatic test_flush;
    fill_two();
    flush_i = 1'b1;
    put(2'd0, 3'd0, 1'b0, 32'd11, 32'd22, 32'd0, 1'b0);
    in_valid_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid_o); end
    end
    checks++; if ({done_cnt_o, illegal_cnt_o} !== {16'(exp_done), 16'(exp_ill)}) begin failures++; $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", done_cnt_o, illegal_cnt_o, exp_done, exp_ill); end
  endtask

  initial begin
    bit sf;
    test_reset();
    test_add();
    test_branch();
    test_srai();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_stream(300, 1'b1, sf);
    test_flush();
    test_stream(20, 1'b1, sf);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
